gg_deblock_writeback: RTL and testbench

GG_DEBLOCK_WRITEBACK -- requirements
Module: gg_deblock_writeback

---
 rtl/gg_deblock_writeback_pkg.sv | 38 +++
 rtl/gg_wb_fifo.sv | 59 +++++
 rtl/gg_deblock_writeback.sv | 136 +++++++++++++
 tb/tb_gg_deblock_writeback.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/gg_deblock_writeback_pkg.sv
// Shared types and helpers for the deblock write-back path: component codes,
// the queued entry layout and the H.264 block index <-> 4x4 coordinate mapping.
package gg_deblock_writeback_pkg;

   typedef enum logic [2:0] {
      LUMA = 3'd0,
      CB   = 3'd2,
      CR   = 3'd3
   } cidx_e;

   localparam int FIFO_DEPTH = 8;
   localparam int DATA_W     = 128;

   typedef struct packed {
      logic [7:0]        mbx;
      logic [7:0]        mby;
      logic [2:0]        cidx;
      logic [3:0]        bidx;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   localparam int ENTRY_W = $bits(wb_entry_t);

   // Luma uses a 4x4 grid of blocks in zig-zag quad order; chroma uses 2x2.
   function automatic logic [1:0] bidx_to_x(input logic luma, input logic [3:0] bidx);
      return luma ? {bidx[2], bidx[0]} : {1'b0, bidx[0]};
   endfunction

   function automatic logic [1:0] bidx_to_y(input logic luma, input logic [3:0] bidx);
      return luma ? {bidx[3], bidx[1]} : {1'b0, bidx[1]};
   endfunction

   function automatic logic [3:0] xy_to_bidx(input logic luma, input logic [1:0] x,
                                             input logic [1:0] y);
      return luma ? {y[1], x[1], y[0], x[0]} : {2'b00, y[0], x[0]};
   endfunction

endpackage

// File: rtl/gg_wb_fifo.sv
// Circular FIFO accepting up to four writes per cycle, packed without gaps in
// lane order, and one read per cycle. DEPTH must be a power of two.
module gg_wb_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 151,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            push,
   input  logic [3:0][WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [WIDTH-1:0]      head,
   output logic [CNT_W-1:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] slot [4];
   logic [2:0]       push_cnt;
   logic             pop_eff;

   // Each active lane lands at wr_ptr plus the number of active lanes before it.
   always_comb begin
      push_cnt = '0;
      for (int i = 0; i < 4; i++) begin
         slot[i]  = wr_ptr + PTR_W'(push_cnt);
         push_cnt = push_cnt + 3'(push[i]);
      end
   end

   assign pop_eff = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (push[i]) begin
            mem[slot[i]] <= push_data[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(push_cnt);
         if (pop_eff) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push_cnt) - CNT_W'(pop_eff);
      end
   end

endmodule

// File: rtl/gg_deblock_writeback.sv
// Routes each filtered 4x4 block from the deblocker to its destination
// macroblock/block index and queues it for write-back in ale, abv, lef, cur order.
module gg_deblock_writeback
   import gg_deblock_writeback_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         valid,
   input  logic [7:0]   mbx,
   input  logic [7:0]   mby,
   input  logic [2:0]   cidx,
   input  logic [3:0]   bidx,
   input  logic         ale_valid,
   input  logic         abv_valid,
   input  logic         lef_valid,
   input  logic         cur_valid,
   input  logic [127:0] ale_filt,
   input  logic [127:0] abv_filt,
   input  logic [127:0] lef_filt,
   input  logic [127:0] cur_filt,
   output logic         in_ready,
   output logic         wr_valid,
   input  logic         wr_ready,
   output logic [7:0]   wr_mbx,
   output logic [7:0]   wr_mby,
   output logic [2:0]   wr_cidx,
   output logic [3:0]   wr_bidx,
   output logic [127:0] wr_data,
   output logic [3:0]   occupancy,
   output logic         overflow,
   output logic         addr_err
);

   logic                      luma;
   logic                      cidx_ok;
   logic [1:0]                x;
   logic [1:0]                y;
   logic [1:0]                max_c;
   logic [3:0]                flags;
   logic [3:0][127:0]         src;
   logic [3:0]                addr_ok;
   logic [3:0]                push;
   logic [3:0][ENTRY_W-1:0]   push_data;
   logic [7:0]                n_mbx;
   logic [7:0]                n_mby;
   logic [1:0]                n_x;
   logic [1:0]                n_y;
   logic                      step_x;
   logic                      step_y;
   wb_entry_t                 entry;
   wb_entry_t                 head;

   // Lane 0..3 = ale, abv, lef, cur; ale and lef step left, ale and abv step up.
   always_comb begin
      luma    = (cidx == LUMA);
      cidx_ok = (cidx == LUMA) || (cidx == CB) || (cidx == CR);
      max_c   = luma ? 2'd3 : 2'd1;
      x       = bidx_to_x(luma, bidx);
      y       = bidx_to_y(luma, bidx);
      flags   = {cur_valid, lef_valid, abv_valid, ale_valid};
      src     = {cur_filt, lef_filt, abv_filt, ale_filt};
      addr_ok   = '1;
      push      = '0;
      push_data = '0;
      for (int i = 0; i < 4; i++) begin
         step_x = (i == 0) || (i == 2);
         step_y = (i == 0) || (i == 1);
         n_mbx  = mbx;
         n_mby  = mby;
         n_x    = x;
         n_y    = y;
         if (step_x) begin
            if (x == 2'd0) begin
               if (mbx == 8'd0) addr_ok[i] = 1'b0;
               n_mbx = mbx - 8'd1;
               n_x   = max_c;
            end else begin
               n_x = x - 2'd1;
            end
         end
         if (step_y) begin
            if (y == 2'd0) begin
               if (mby == 8'd0) addr_ok[i] = 1'b0;
               n_mby = mby - 8'd1;
               n_y   = max_c;
            end else begin
               n_y = y - 2'd1;
            end
         end
         entry.mbx    = n_mbx;
         entry.mby    = n_mby;
         entry.cidx   = cidx;
         entry.bidx   = xy_to_bidx(luma, n_x, n_y);
         entry.data   = src[i];
         push_data[i] = entry;
         push[i]      = !reset && valid && in_ready && cidx_ok && flags[i] && addr_ok[i];
      end
   end

   gg_wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (wr_valid && wr_ready),
      .head      (head),
      .count     (occupancy)
   );

   assign in_ready = (occupancy <= 4'd4);
   assign wr_valid = (occupancy != 4'd0);
   assign wr_mbx   = head.mbx;
   assign wr_mby   = head.mby;
   assign wr_cidx  = head.cidx;
   assign wr_bidx  = head.bidx;
   assign wr_data  = head.data;

   // Sticky error flags; a blocked cycle drops every flagged block it carried.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow <= 1'b0;
         addr_err <= 1'b0;
      end else if (valid) begin
         if (!in_ready && (flags != 4'd0)) begin
            overflow <= 1'b1;
         end
         if (!cidx_ok || ((flags & ~addr_ok) != 4'd0)) begin
            addr_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gg_deblock_writeback.sv
// Directed self-checking bench for gg_deblock_writeback with hand-computed
// destinations for in-MB, cross-MB, chroma, edge and backpressure cases.
module tb_gg_deblock_writeback;

   logic         clk = 1'b0;
   logic         reset;
   logic         valid;
   logic [7:0]   mbx;
   logic [7:0]   mby;
   logic [2:0]   cidx;
   logic [3:0]   bidx;
   logic         ale_valid;
   logic         abv_valid;
   logic         lef_valid;
   logic         cur_valid;
   logic [127:0] ale_filt;
   logic [127:0] abv_filt;
   logic [127:0] lef_filt;
   logic [127:0] cur_filt;
   logic         in_ready;
   logic         wr_valid;
   logic         wr_ready;
   logic [7:0]   wr_mbx;
   logic [7:0]   wr_mby;
   logic [2:0]   wr_cidx;
   logic [3:0]   wr_bidx;
   logic [127:0] wr_data;
   logic [3:0]   occupancy;
   logic         overflow;
   logic         addr_err;

   int check_count = 0;
   int error_count = 0;

   gg_deblock_writeback dut (
      .clk       (clk),
      .reset     (reset),
      .valid     (valid),
      .mbx       (mbx),
      .mby       (mby),
      .cidx      (cidx),
      .bidx      (bidx),
      .ale_valid (ale_valid),
      .abv_valid (abv_valid),
      .lef_valid (lef_valid),
      .cur_valid (cur_valid),
      .ale_filt  (ale_filt),
      .abv_filt  (abv_filt),
      .lef_filt  (lef_filt),
      .cur_filt  (cur_filt),
      .in_ready  (in_ready),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_mbx    (wr_mbx),
      .wr_mby    (wr_mby),
      .wr_cidx   (wr_cidx),
      .wr_bidx   (wr_bidx),
      .wr_data   (wr_data),
      .occupancy (occupancy),
      .overflow  (overflow),
      .addr_err  (addr_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [159:0] got,
                              input logic [159:0] exp);
      check_count++;
      if (got !== exp) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // fl bits: [3] ale, [2] abv, [1] lef, [0] cur; block bytes are {A|B|C|D, n}.
   task automatic driveInputs(input logic v, input logic [7:0] mx, input logic [7:0] my,
                              input logic [2:0] c, input logic [3:0] b,
                              input logic [3:0] fl, input logic [3:0] n);
      valid     = v;
      mbx       = mx;
      mby       = my;
      cidx      = c;
      bidx      = b;
      ale_valid = fl[3];
      abv_valid = fl[2];
      lef_valid = fl[1];
      cur_valid = fl[0];
      ale_filt  = {16{4'hA, n}};
      abv_filt  = {16{4'hB, n}};
      lef_filt  = {16{4'hC, n}};
      cur_filt  = {16{4'hD, n}};
   endtask

   task automatic clearInputs();
      driveInputs(1'b0, 8'd0, 8'd0, 3'd0, 4'd0, 4'd0, 4'd0);
   endtask

   task automatic applyStimulus(input logic [7:0] mx, input logic [7:0] my,
                                input logic [2:0] c, input logic [3:0] b,
                                input logic [3:0] fl, input logic [3:0] n);
      driveInputs(1'b1, mx, my, c, b, fl, n);
      @(posedge clk);
      #1;
      clearInputs();
   endtask

   task automatic expectHead(input string tag, input logic [7:0] mx, input logic [7:0] my,
                             input logic [2:0] c, input logic [3:0] b, input logic [7:0] d);
      checkOutput({tag, " head"}, {wr_valid, wr_mbx, wr_mby, wr_cidx, wr_bidx},
                  {1'b1, mx, my, c, b});
      checkOutput({tag, " data"}, wr_data, {16{d}});
   endtask

   task automatic popEntry(input string tag, input logic [7:0] mx, input logic [7:0] my,
                           input logic [2:0] c, input logic [3:0] b, input logic [7:0] d);
      expectHead(tag, mx, my, c, b, d);
      wr_ready = 1'b1;
      @(posedge clk);
      #1;
      wr_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset    = 1'b1;
      wr_ready = 1'b0;
      clearInputs();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("reset state", {occupancy, wr_valid, in_ready, overflow, addr_err},
                  {4'd0, 1'b0, 1'b1, 1'b0, 1'b0});

      // Four outputs of one luma block, drained while being pushed.
      wr_ready = 1'b1;
      driveInputs(1'b1, 8'd1, 8'd1, 3'd0, 4'd3, 4'b1111, 4'h1);
      #1;
      checkOutput("t1 no comb path", wr_valid, 1'b0);
      @(posedge clk);
      #1;
      clearInputs();
      checkOutput("t1 peak occupancy", occupancy, 4'd4);
      expectHead("t1 e0", 8'd1, 8'd1, 3'd0, 4'd0, 8'hA1);
      @(posedge clk); #1;
      expectHead("t1 e1", 8'd1, 8'd1, 3'd0, 4'd1, 8'hB1);
      @(posedge clk); #1;
      expectHead("t1 e2", 8'd1, 8'd1, 3'd0, 4'd2, 8'hC1);
      @(posedge clk); #1;
      expectHead("t1 e3", 8'd1, 8'd1, 3'd0, 4'd3, 8'hD1);
      @(posedge clk); #1;
      checkOutput("t1 drained", {wr_valid, occupancy}, 5'd0);
      wr_ready = 1'b0;

      // Luma neighbours crossing left and upper macroblock boundaries.
      applyStimulus(8'd2, 8'd1, 3'd0, 4'd0, 4'b1110, 4'h2);
      checkOutput("t2 occupancy", occupancy, 4'd3);
      popEntry("t2 ale", 8'd1, 8'd0, 3'd0, 4'd15, 8'hA2);
      popEntry("t2 abv", 8'd2, 8'd0, 3'd0, 4'd10, 8'hB2);
      popEntry("t2 lef", 8'd1, 8'd1, 3'd0, 4'd5, 8'hC2);
      checkOutput("t2 addr_err clear", addr_err, 1'b0);

      // Chroma neighbours.
      applyStimulus(8'd1, 8'd1, 3'd3, 4'd0, 4'b1001, 4'h3);
      checkOutput("t3 occupancy", occupancy, 4'd2);
      popEntry("t3 ale", 8'd0, 8'd0, 3'd3, 4'd3, 8'hA3);
      popEntry("t3 cur", 8'd1, 8'd1, 3'd3, 4'd0, 8'hD3);

      // Simultaneous push and pop, chroma horizontal underflow.
      applyStimulus(8'd5, 8'd6, 3'd2, 4'd1, 4'b0001, 4'h4);
      expectHead("t4 cur", 8'd5, 8'd6, 3'd2, 4'd1, 8'hD4);
      wr_ready = 1'b1;
      applyStimulus(8'd5, 8'd6, 3'd2, 4'd2, 4'b0010, 4'h5);
      wr_ready = 1'b0;
      checkOutput("t4 push+pop occupancy", occupancy, 4'd1);
      popEntry("t4 lef", 8'd4, 8'd6, 3'd2, 4'd3, 8'hC5);

      // Left neighbour off the picture edge.
      applyStimulus(8'd0, 8'd0, 3'd0, 4'd0, 4'b0010, 4'h6);
      checkOutput("t5 nothing queued", {wr_valid, occupancy}, 5'd0);
      checkOutput("t5 addr_err set", addr_err, 1'b1);

      // Backpressure: in_ready holds at occupancy 4 and drops above it.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(8'(3 + k), 8'd3, 3'd0, 4'd5, 4'b0101, 4'(7 + k));
         checkOutput($sformatf("t6 occupancy %0d", k), occupancy, 4'(2 * k + 2));
         checkOutput($sformatf("t6 in_ready %0d", k), in_ready, (k < 2) ? 1'b1 : 1'b0);
      end
      checkOutput("t6 overflow clear", overflow, 1'b0);
      applyStimulus(8'd9, 8'd3, 3'd0, 4'd5, 4'b0101, 4'hF);
      checkOutput("t6 overflow set", overflow, 1'b1);
      checkOutput("t6 occupancy held", occupancy, 4'd6);
      checkOutput("t6 addr_err sticky", addr_err, 1'b1);
      for (int k = 0; k < 3; k++) begin
         popEntry($sformatf("t6 abv %0d", k), 8'(3 + k), 8'd2, 3'd0, 4'd15, {4'hB, 4'(7 + k)});
         popEntry($sformatf("t6 cur %0d", k), 8'(3 + k), 8'd3, 3'd0, 4'd5, {4'hD, 4'(7 + k)});
      end
      checkOutput("t6 drained", {wr_valid, occupancy}, 5'd0);

      // Reset with five entries queued and a flagged input present.
      applyStimulus(8'd1, 8'd1, 3'd0, 4'd3, 4'b1111, 4'h1);
      applyStimulus(8'd1, 8'd1, 3'd0, 4'd3, 4'b0001, 4'h2);
      checkOutput("t7 occupancy", occupancy, 4'd5);
      driveInputs(1'b1, 8'd1, 8'd1, 3'd0, 4'd3, 4'b1111, 4'h3);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      clearInputs();
      checkOutput("t7 after reset", {occupancy, wr_valid, overflow, addr_err, in_ready},
                  {4'd0, 1'b0, 1'b0, 1'b0, 1'b1});

      // Unsupported component code.
      applyStimulus(8'd1, 8'd1, 3'd1, 4'd0, 4'b0001, 4'h4);
      checkOutput("t8 nothing queued", occupancy, 4'd0);
      checkOutput("t8 addr_err", addr_err, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule
